// File: rtl/div_pkg.sv
// Shared types and helpers for the shift/subtract restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Width of a step counter that must hold 0..w-1.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor if it fits, and shift the resulting quotient bit in.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_dvd_q,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem_next,
  output logic [WIDTH-1:0] o_dvd_q_next
);

  logic [WIDTH:0]   w_partial;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  assign w_partial = {i_rem, i_dvd_q[WIDTH-1]};
  assign w_ge      = (w_partial >= {1'b0, i_divisor});
  // When the divisor fits, the true difference is < divisor, so WIDTH bits suffice.
  assign w_diff    = w_partial[WIDTH-1:0] - i_divisor;

  assign o_rem_next   = w_ge ? w_diff : w_partial[WIDTH-1:0];
  assign o_dvd_q_next = {i_dvd_q[WIDTH-2:0], w_ge};

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider, one quotient bit per cycle, start/busy/done handshake.
// Normal result after WIDTH CALC cycles; divide-by-zero resolves after a single CALC cycle.
module shift_sub_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       r_state, w_state_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rem, r_dvd, r_dvs;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quot, r_remd;
  logic             r_dbz_o;
  logic [WIDTH-1:0] w_rem_next, w_dvd_next;
  logic             w_accept;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem        (r_rem),
    .i_dvd_q      (r_dvd),
    .i_divisor    (r_dvs),
    .o_rem_next   (w_rem_next),
    .o_dvd_q_next (w_dvd_next)
  );

  assign w_accept = (r_state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = CALC;
      CALC:    if (r_dbz || r_count == LAST) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // A zero divisor skips the step loop and settles on its first CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_dbz   <= 1'b0;
      r_quot  <= '0;
      r_remd  <= '0;
      r_dbz_o <= 1'b0;
    end else if (w_accept) begin
      r_count <= '0;
      r_rem   <= '0;
      r_dvd   <= dividend;
      r_dvs   <= divisor;
      r_dbz   <= (divisor == '0);
    end else if (r_state == CALC) begin
      if (r_dbz) begin
        r_quot  <= '1;
        r_remd  <= r_dvd;
        r_dbz_o <= 1'b1;
      end else begin
        r_rem   <= w_rem_next;
        r_dvd   <= w_dvd_next;
        r_count <= r_count + 1'b1;
        if (r_count == LAST) begin
          r_quot  <= w_dvd_next;
          r_remd  <= w_rem_next;
          r_dbz_o <= 1'b0;
        end
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_remd;
  assign div_by_zero = r_dbz_o;

`ifdef FORMAL
  logic [WIDTH-1:0] f_dvd, f_dvs;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_dvd <= '0;
      f_dvs <= '0;
    end else if (w_accept) begin
      f_dvd <= dividend;
      f_dvs <= divisor;
    end
  end

  a_inv: assert property (@(posedge clk) disable iff (!rst_n)
    (done && !div_by_zero) |->
      ((2*WIDTH)'(quotient) * (2*WIDTH)'(f_dvs) + (2*WIDTH)'(remainder) == (2*WIDTH)'(f_dvd))
      && (remainder < f_dvs));
  a_pulse: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
  a_busy: assert property (@(posedge clk) disable iff (!rst_n) busy == (r_state != IDLE));
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    !$rose(done) |-> ($stable(quotient) && $stable(remainder) && $stable(div_by_zero)));
`endif

endmodule

// File: tb/tb_shift_sub_divider.sv
// Randomized and directed bench for shift_sub_divider against an arithmetic reference.
module tb_shift_sub_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_checks = 0;
  int n_err = 0;

  shift_sub_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? {W{1'b1}} : a / b;
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  // Launch one operation; report latency (negedges after accept until done seen),
  // busy cycles up to done, captured results and the state one cycle later.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                        output logic done_after, output logic [W-1:0] q_after);
    int g;
    g = 0;
    while (busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat = 0; bcnt = 0; q = '0; r = '0; z = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = k; q = quotient; r = remainder; z = div_by_zero;
        break;
      end
    end
    @(negedge clk);
    done_after = done;
    q_after    = quotient;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got busy/done/dbz=%b expected 000", {busy, done, div_by_zero});
    end
    n_checks++;
    if ({quotient, remainder} !== '0) begin
      n_err++; $display("FAIL reset_results got q=%0d r=%0d expected 0 0", quotient, remainder);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] a_t [4] = '{8'd200, 8'd255, 8'd5, 8'd0};
    logic [W-1:0] b_t [4] = '{8'd7,   8'd1,   8'd9, 8'd3};
    logic [W-1:0] eq_t[4] = '{8'd28,  8'd255, 8'd0, 8'd0};
    logic [W-1:0] er_t[4] = '{8'd4,   8'd0,   8'd5, 8'd0};
    int lat, bcnt;
    logic [W-1:0] q, r, qa;
    logic z, da;
    for (int i = 0; i < 4; i++) begin
      run_op(a_t[i], b_t[i], lat, bcnt, q, r, z, da, qa);
      n_checks++;
      if (q !== eq_t[i] || r !== er_t[i] || z !== 1'b0) begin
        n_err++; $display("FAIL directed_%0d got q=%0d r=%0d z=%b expected q=%0d r=%0d z=0",
                          i, q, r, z, eq_t[i], er_t[i]);
      end
      n_checks++;
      if (lat !== W + 1) begin
        n_err++; $display("FAIL directed_latency_%0d got %0d expected %0d", i, lat, W + 1);
      end
      n_checks++;
      if (da !== 1'b0 || qa !== eq_t[i]) begin
        n_err++; $display("FAIL directed_pulse_hold_%0d got done=%b q=%0d expected done=0 q=%0d",
                          i, da, qa, eq_t[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int lat, bcnt;
    logic [W-1:0] q, r, qa;
    logic z, da;
    run_op(8'd100, 8'd0, lat, bcnt, q, r, z, da, qa);
    n_checks++;
    if (q !== 8'd255 || r !== 8'd100 || z !== 1'b1) begin
      n_err++; $display("FAIL dbz_result got q=%0d r=%0d z=%b expected q=255 r=100 z=1", q, r, z);
    end
    n_checks++;
    if (lat !== 2 || bcnt !== 2) begin
      n_err++; $display("FAIL dbz_timing got lat=%0d busy=%0d expected lat=2 busy=2", lat, bcnt);
    end
    n_checks++;
    if (da !== 1'b0) begin
      n_err++; $display("FAIL dbz_pulse got done=%b one cycle later expected 0", da);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, bcnt, g;
    logic [W-1:0] q, r, qa;
    logic z, da;
    @(negedge clk);
    dividend = 8'd200; divisor = 8'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; dividend = 8'd50; divisor = 8'd5;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    g = 0;
    while (!done && g < 40) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (done !== 1'b1 || quotient !== 8'd28 || remainder !== 8'd4) begin
      n_err++; $display("FAIL busy_ignore got done=%b q=%0d r=%0d expected done=1 q=28 r=4",
                        done, quotient, remainder);
    end
    run_op(8'd50, 8'd5, lat, bcnt, q, r, z, da, qa);
    n_checks++;
    if (q !== 8'd10 || r !== 8'd0 || lat !== W + 1) begin
      n_err++; $display("FAIL busy_followup got q=%0d r=%0d lat=%0d expected q=10 r=0 lat=%0d",
                        q, r, lat, W + 1);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt;
    logic [W-1:0] q, r, qa;
    logic z, da;
    run_op(8'd200, 8'd7, lat, bcnt, q, r, z, da, qa);
    @(negedge clk);
    dividend = 8'd77; divisor = 8'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      n_err++; $display("FAIL reset_mid got busy=%b done=%b dbz=%b q=%0d r=%0d expected all 0",
                        busy, done, div_by_zero, quotient, remainder);
    end
    #3;
    rst_n = 1'b1;
    run_op(8'd9, 8'd2, lat, bcnt, q, r, z, da, qa);
    n_checks++;
    if (q !== 8'd4 || r !== 8'd1 || z !== 1'b0 || lat !== W + 1) begin
      n_err++; $display("FAIL reset_recover got q=%0d r=%0d z=%b lat=%0d expected q=4 r=1 z=0 lat=%0d",
                        q, r, z, lat, W + 1);
    end
  endtask

  task automatic test_random();
    int lat, bcnt, exp_lat;
    logic [W-1:0] a, b, q, r, qa;
    logic z, da;
    for (int i = 0; i < 400; i++) begin
      case (i)
        0: begin a = 8'd255; b = 8'd255; end
        1: begin a = 8'd0;   b = 8'd0;   end
        2: begin a = 8'd1;   b = 8'd255; end
        3: begin a = 8'd254; b = 8'd255; end
        4: begin a = 8'd255; b = 8'd2;   end
        default: begin
          a = W'($urandom);
          b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
        end
      endcase
      exp_lat = (b == 0) ? 2 : W + 1;
      run_op(a, b, lat, bcnt, q, r, z, da, qa);
      n_checks++;
      if (q !== ref_q(a, b) || r !== ref_r(a, b) || z !== (b == 0) ||
          lat !== exp_lat || bcnt !== exp_lat || da !== 1'b0 || qa !== q) begin
        n_err++;
        $display("FAIL random %0d/%0d got q=%0d r=%0d z=%b lat=%0d busy=%0d expected q=%0d r=%0d z=%b lat=%0d",
                 a, b, q, r, z, lat, bcnt, ref_q(a, b), ref_r(a, b), (b == 0), exp_lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
